// File: rtl/mm_uart_tx.sv
// mm_uart_tx: memory-mapped 8N1 UART transmitter with TX FIFO; clk/reset_n, bus select/wstrb/addr/data_i -> ready/data_o, serial tx
module mm_uart_tx #(
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd234
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        select,
  input  logic [3:0]  wstrb,
  input  logic [3:0]  addr,
  input  logic [31:0] data_i,
  output logic        ready,
  output logic [31:0] data_o,
  output logic        tx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          ovf;
  logic [15:0]   div, cnt, div_new;
  logic [2:0]    bitn;
  logic [7:0]    sh;
  logic          commit, push, push_ok, pop, full, empty, bit_end, ovf_clr, div_wr;
  logic [31:0]   rdata;
  logic          unused_ok;
  assign unused_ok = ^{data_i[31:16], addr[1:0], wstrb[3:2]};
  always_comb begin
    commit  = select & ~ready;
    full    = count == (AW+1)'(FIFO_DEPTH);
    empty   = count == '0;
    bit_end = cnt == 16'd0;
    push    = commit & addr[3:2] == 2'd0 & wstrb[0];
    pop     = ~empty & (state == IDLE | (state == STOP & bit_end));
    push_ok = push & (~full | pop);
    ovf_clr = commit & addr[3:2] == 2'd1 & wstrb[0] & data_i[3];
    div_wr  = commit & addr[3:2] == 2'd2 & |wstrb[1:0];
    div_new = {wstrb[1] ? data_i[15:8] : div[15:8], wstrb[0] ? data_i[7:0] : div[7:0]};
    rdata   = addr[3:2] == 2'd1 ? 32'({count, 4'b0, ovf, empty, full, state != IDLE}) :
              addr[3:2] == 2'd2 ? {16'd0, div} : 32'd0;
  end
  always_ff @(posedge clk)
    if (push_ok) mem[wptr] <= data_i[7:0];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready  <= 1'b0;
      data_o <= 32'd0;
      tx     <= 1'b1;
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      div    <= DEFAULT_DIV;
      state  <= IDLE;
      cnt    <= 16'd0;
      bitn   <= 3'd0;
      sh     <= 8'd0;
    end else begin
      ready <= commit;
      if (commit) data_o <= rdata;
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
      if (push & ~push_ok) ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
      if (div_wr) div <= div_new < 16'd2 ? 16'd2 : div_new;
      tx <= state == START ? 1'b0 : state == DATA ? sh[0] : 1'b1;
      case (state)
        IDLE: if (pop) begin
          sh    <= mem[rptr];
          cnt   <= div - 16'd1;
          state <= START;
        end
        START: if (bit_end) begin
          cnt   <= div - 16'd1;
          bitn  <= 3'd0;
          state <= DATA;
        end else cnt <= cnt - 16'd1;
        DATA: if (bit_end) begin
          cnt   <= div - 16'd1;
          sh    <= {1'b0, sh[7:1]};
          bitn  <= bitn + 3'd1;
          state <= bitn == 3'd7 ? STOP : DATA;
        end else cnt <= cnt - 16'd1;
        STOP: if (bit_end) begin
          cnt   <= div - 16'd1;
          sh    <= pop ? mem[rptr] : sh;
          state <= pop ? START : IDLE;
        end else cnt <= cnt - 16'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mm_uart_tx.sv
// tb_mm_uart_tx: directed and randomized checks of mm_uart_tx against a frame-level UART model
module tb_mm_uart_tx;
  logic        clk = 0, reset_n = 0, select = 0, ready, tx;
  logic [3:0]  wstrb = 0, addr = 0;
  logic [31:0] data_i = 0, data_o, r;
  int          checks = 0, errors = 0, cyc = 0, hn = 0, rp = 0, last_commit = 0;
  bit          tx_hist [100000];
  mm_uart_tx dut (.clk(clk), .reset_n(reset_n), .select(select), .wstrb(wstrb), .addr(addr),
                  .data_i(data_i), .ready(ready), .data_o(data_o), .tx(tx));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    tx_hist[cyc] = tx;
    hn = cyc + 1;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic bus(input logic [3:0] a, input logic [3:0] s, input logic [31:0] d, output logic [31:0] q);
    bit got = 0;
    select = 1; addr = a; wstrb = s; data_i = d;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk); #1;
      got = ready;
    end
    chk("bus_ready", 32'(got), 32'd1);
    last_commit = cyc;
    q = data_o;
    select = 0; wstrb = 0;
  endtask
  function automatic logic [31:0] st_word(bit busy, int lvl, bit ov);
    return {19'd0, 5'(lvl), 4'd0, ov, lvl == 0, lvl == 16, busy};
  endfunction
  function automatic logic [15:0] div_upd(logic [15:0] cur, logic [3:0] s, logic [31:0] d);
    logic [15:0] n = cur;
    if (s[0]) n[7:0] = d[7:0];
    if (s[1]) n[15:8] = d[15:8];
    return n < 2 ? 16'd2 : n;
  endfunction
  task automatic dec_frame(input logic [7:0] b, input int d, output int st);
    int bad = 0;
    logic [7:0] rx = 0;
    logic e;
    st = -1;
    for (int i = 0; i < 400 && st < 0; i++) begin
      while (hn <= rp) @(negedge clk);
      if (tx_hist[rp] == 1'b0) st = rp;
      rp++;
    end
    chk("frame_start", 32'(st >= 0), 32'd1);
    if (st < 0) return;
    rp = st;
    for (int k = 0; k < 10; k++) begin
      e = k == 0 ? 1'b0 : k == 9 ? 1'b1 : b[k-1];
      for (int j = 0; j < d; j++) begin
        while (hn <= rp) @(negedge clk);
        if (tx_hist[rp] !== e) bad++;
        if (k > 0 && k < 9 && j == d / 2) rx[k-1] = tx_hist[rp];
        rp++;
      end
    end
    chk("frame_byte", 32'(rx), 32'(b));
    chk("frame_bits", bad, 0);
  endtask
  initial begin
    int st, st1, c0, d, n, zeros;
    logic [7:0] q[$];
    logic [15:0] mdiv;
    logic [3:0] s;
    logic [31:0] wd;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_data_o", data_o, 32'd0);
    reset_n = 1;
    bus(4'h8, 4'b0000, 0, r); chk("rst_div", r, 32'h0000_00EA);
    bus(4'h4, 4'b0000, 0, r); chk("rst_status", r, st_word(0, 0, 0));
    bus(4'hC, 4'b0000, 0, r); chk("rsvd_read", r, 32'd0);
    bus(4'h0, 4'b0000, 0, r); chk("data_read", r, 32'd0);
    // single byte at divider 4
    rp = cyc;
    bus(4'h8, 4'b0011, 4, r);
    bus(4'h0, 4'b0001, 32'h55, r);
    c0 = last_commit;
    bus(4'h4, 4'b0000, 0, r); chk("single_busy", r, st_word(1, 0, 0));
    dec_frame(8'h55, 4, st);
    chk("single_latency", st, c0 + 2);
    bus(4'h4, 4'b0000, 0, r); chk("single_idle", r, st_word(0, 0, 0));
    // back-to-back frames
    rp = cyc;
    bus(4'h0, 4'b0001, 32'hA5, r);
    c0 = last_commit;
    bus(4'h0, 4'b0001, 32'h3C, r);
    bus(4'h4, 4'b0000, 0, r); chk("b2b_level", r, st_word(1, 1, 0));
    dec_frame(8'hA5, 4, st1);
    chk("b2b_latency", st1, c0 + 2);
    dec_frame(8'h3C, 4, st);
    chk("b2b_nogap", st, st1 + 40);
    bus(4'h4, 4'b0000, 0, r); chk("b2b_idle", r, st_word(0, 0, 0));
    // random bursts with random divider
    for (int it = 0; it < 3; it++) begin
      d = $urandom_range(2, 5);
      n = $urandom_range(1, 4);
      q = {};
      rp = cyc;
      bus(4'h8, 4'b0011, d, r);
      for (int k = 0; k < n; k++) begin
        q.push_back(8'($urandom));
        bus(4'h0, 4'b0001, {24'($urandom), q[k]}, r);
        if (k == 0) c0 = last_commit;
      end
      for (int k = 0; k < n; k++) begin
        dec_frame(q[k], d, st);
        chk(k == 0 ? "rnd_latency" : "rnd_nogap", st, k == 0 ? c0 + 2 : st1 + 10 * d);
        st1 = st;
      end
      bus(4'h4, 4'b0000, 0, r); chk("rnd_idle", r, st_word(0, 0, 0));
    end
    // overflow with a very slow divider
    bus(4'h8, 4'b0011, 32'hFFFF, r);
    for (int k = 0; k < 17; k++) bus(4'h0, 4'b0001, $urandom, r);
    bus(4'h4, 4'b0000, 0, r); chk("ovf_full", r, st_word(1, 16, 0));
    bus(4'h0, 4'b0001, $urandom, r);
    bus(4'h4, 4'b0000, 0, r); chk("ovf_set", r, st_word(1, 16, 1));
    bus(4'h4, 4'b0001, 32'h8, r);
    bus(4'h4, 4'b0000, 0, r); chk("ovf_clear", r, st_word(1, 16, 0));
    // divider clamp and byte lanes
    bus(4'h8, 4'b0011, 32'h1, r);
    bus(4'h8, 4'b0000, 0, r); chk("div_clamp", r, 32'd2);
    bus(4'h8, 4'b0010, 32'h1200, r);
    bus(4'h8, 4'b0000, 0, r); chk("div_lane", r, 32'h1202);
    mdiv = 16'h1202;
    for (int k = 0; k < 6; k++) begin
      wd = $urandom;
      if (k % 2 == 1) wd[15:0] = 16'($urandom_range(0, 3));
      s = 4'($urandom_range(1, 15));
      bus(4'h8, s, wd, r);
      mdiv = div_upd(mdiv, s, wd);
      bus(4'h8, 4'b0000, 0, r); chk("div_rnd", r, {16'd0, mdiv});
    end
    // reset during a slow frame clears everything
    reset_n = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    bus(4'h4, 4'b0000, 0, r); chk("rst2_status", r, st_word(0, 0, 0));
    bus(4'h8, 4'b0000, 0, r); chk("rst2_div", r, 32'h0000_00EA);
    // reset in data bit 3 with bytes still queued
    bus(4'h8, 4'b0011, 4, r);
    bus(4'h0, 4'b0001, 32'h00, r);
    c0 = last_commit;
    bus(4'h0, 4'b0001, 32'hFF, r);
    bus(4'h0, 4'b0001, 32'h81, r);
    while (cyc < c0 + 19) begin
      @(posedge clk); #1;
    end
    chk("mid_bit3_low", 32'(tx), 32'd0);
    reset_n = 0;
    #1;
    chk("mid_rst_tx", 32'(tx), 32'd1);
    repeat (3) @(posedge clk);
    #1 reset_n = 1;
    rp = cyc;
    zeros = 0;
    for (int k = 0; k < 50; k++) begin
      while (hn <= rp) @(negedge clk);
      if (tx_hist[rp] == 1'b0) zeros++;
      rp++;
    end
    chk("mid_no_residual", zeros, 0);
    bus(4'h4, 4'b0000, 0, r); chk("mid_status", r, st_word(0, 0, 0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mm_uart_tx.md
Name: mm_uart_tx

Overview:
Memory-mapped UART transmitter, a responder on the CPU native memory bus alongside the SRAM, flash and LED slaves. It uses the same slave handshake: select, wstrb, addr, data_i, ready and data_o. The CPU pushes bytes into a TX FIFO; a bit-timing state machine serialises them as 8N1 frames on tx. A status register and a baud divider register are readable by software.

Parameters:
FIFO_DEPTH, 16, number of TX FIFO entries; must be a power of two, minimum 2.
DEFAULT_DIV, 234, reset value of DIVIDER in clocks per bit (27 MHz / 115200).

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
select  input  1  slave select from address decoder, already qualified with mem_valid
wstrb  input  4  byte write strobes; all-zero means read
addr  input  4  byte offset within block; addr[3:2] selects register, addr[1:0] ignored
data_i  input  32  write data
ready  output  1  one-cycle transaction acknowledge
data_o  output  32  read data, valid while ready=1
tx  output  1  serial output, idle high

Behaviour:
- Reset (async, while reset_n=0): ready=0, data_o=0, tx=1, FIFO emptied, overflow=0, DIVIDER=DEFAULT_DIV, FSM=IDLE. Applies immediately, including in the middle of a frame.
- Handshake: ready is registered as ready <= select & ~ready. It is high for exactly one cycle, one clock after select is seen high.
  - Each transaction's side effects commit on the edge where ready rises, exactly once per transaction.
  - Back-to-back transactions are allowed: select may stay low for one cycle after ready and then rise again.
- data_o is loaded on that same edge and holds its value otherwise.
- Register map:
  - 0x0 DATA. Write with wstrb[0]=1 pushes data_i[7:0]. Read returns 0.
  - 0x4 STATUS (read):
    - bit0 busy (FSM != IDLE)
    - bit1 full
    - bit2 empty
    - bit3 overflow (sticky)
    - bits[8+$clog2(FIFO_DEPTH):8] fill level, range 0..FIFO_DEPTH
    - all other bits 0
  - 0x4 STATUS (write): writing with wstrb[0]=1 and data_i[3]=1 clears overflow.
  - 0x8 DIVIDER, bits[15:0]. Byte lanes are written per wstrb[1:0]. If the resulting value is <2, 2 is stored. Read returns the value zero-extended.
  - 0xC reserved. Read returns 0; writes are ignored; ready is still given.
- FIFO:
  - A push when full drops the byte and sets overflow. Contents and count are unchanged.
  - A push and a pop on the same edge both take effect, so the count is unchanged. This applies even when full: a pop on that edge makes room and the push succeeds.
  - Pointers wrap modulo FIFO_DEPTH.
- TX FSM, with bit counter and 16-bit baud counter:
  - IDLE: tx=1. If the FIFO is not empty, pop into the shift register, load the baud counter, and go to START.
  - START: tx=0 for DIVIDER clocks, then go to DATA.
  - DATA: 8 bits, LSB first, each bit for DIVIDER clocks, then go to STOP.
  - STOP: tx=1 for DIVIDER clocks. At the end, if the FIFO is not empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
- Latency: a DATA write committed at edge N with FSM in IDLE makes tx fall at edge N+2.
- DIVIDER changes mid-frame take effect at the next bit boundary. The current bit completes with the old value.
- tx is a registered output (glitch-free).

Test Plan:
- Reset: hold reset_n=0 → tx=1, ready=0, data_o=0. Then read 0x8 → 0x000000EA; read 0x4 → 0x00000004 (empty).
- Single byte: write DIVIDER=4, then write 0x55 to 0x0 → tx low for 4 clks, then bits 1,0,1,0,1,0,1,0 at 4 clks each, then stop high for 4 clks. busy=1 for 40 clks after start.
- Back-to-back: write 0xA5 then 0x3C while busy → second start bit begins on the clock immediately after the first stop bit ends. Status level goes 1→0 at the first pop.
- Overflow: with DIVIDER=0xFFFF, write 17 bytes (first popped immediately, then 16 fill the FIFO), then write one more → STATUS full=1, overflow=1, level=16. Write 0x8 to 0x4 → overflow=0, full still 1.
- Divider clamp and lanes: write 0x00000001 with wstrb=0011 → read 0x8 = 2. Write 0x1200 with wstrb=0010 → read 0x8 = 0x1202.
- Reset mid-frame: assert reset_n=0 during DATA bit 3 → tx=1 the same cycle, FIFO empty after release, no residual frame output.
